pipe_hazard_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage core.
- Drives the hold and bubble controls of the PC, IF/ID, ID/EX and EX/MEM pipeline registers.
- Detects load-use hazards between ID and EX, freezes the pipe while a MEM-stage data access waits for acknowledge, and squashes wrong-path instructions after a taken branch or jump resolved in EX.

---
 rtl/pipe_hazard_ctrl_if.sv | 15 +
 rtl/pipe_hazard_ctrl.sv | 62 ++++++
 tb/tb_pipe_hazard_ctrl.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: hazard inputs from ID/EX/MEM and pipeline stall/flush controls
interface pipe_hazard_ctrl_if #(parameter int RD_WIDTH = 5);
  logic [RD_WIDTH-1:0] rs1_id, rs2_id, rd_ex;
  logic rs1_used_id, rs2_used_id, mem_read_ex, branch_taken_ex, mem_req_mem, mem_ack;
  logic stall_pc, stall_if_id, flush_if_id, stall_id_ex, flush_id_ex, stall_ex_mem, mem_timeout;
  logic [1:0] state_o;
  modport master (
    output rs1_id, rs2_id, rd_ex, rs1_used_id, rs2_used_id, mem_read_ex, branch_taken_ex, mem_req_mem, mem_ack,
    input stall_pc, stall_if_id, flush_if_id, stall_id_ex, flush_id_ex, stall_ex_mem, mem_timeout, state_o
  );
  modport slave (
    input rs1_id, rs2_id, rd_ex, rs1_used_id, rs2_used_id, mem_read_ex, branch_taken_ex, mem_req_mem, mem_ack,
    output stall_pc, stall_if_id, flush_if_id, stall_id_ex, flush_id_ex, stall_ex_mem, mem_timeout, state_o
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for load-use, data-bus wait and branch redirect
module pipe_hazard_ctrl #(
  parameter int RD_WIDTH = 5,
  parameter int REDIRECT_BUBBLES = 1,
  parameter int MEM_TIMEOUT = 255
) (
  input logic clk,
  input logic rst_n,
  pipe_hazard_ctrl_if.slave hz
);
  typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, REDIRECT = 2'd2} state_t;
  state_t state_q, state_d;
  logic [1:0] rcnt_q, rcnt_d;
  logic [7:0] wcnt_q, wcnt_d;
  logic mem_timeout_q, mem_timeout_d;
  logic memwait, redir_like, redirect, loaduse, loaduse_v;
  // A wait entered from REDIRECT keeps rcnt nonzero, so the ack cycle still flushes IF/ID
  always_comb begin
    memwait = (state_q == MEM_WAIT) ? ~hz.mem_ack : hz.mem_req_mem & ~hz.mem_ack;
    redir_like = (state_q == REDIRECT) || (state_q == MEM_WAIT && rcnt_q != 2'd0);
    loaduse = hz.mem_read_ex & (hz.rd_ex != '0) &
              ((hz.rs1_used_id & (hz.rs1_id == hz.rd_ex)) | (hz.rs2_used_id & (hz.rs2_id == hz.rd_ex)));
    redirect = ~redir_like & ~memwait & hz.branch_taken_ex;
    loaduse_v = ~redir_like & ~memwait & ~hz.branch_taken_ex & loaduse;
    hz.stall_pc = rst_n & (memwait | loaduse_v);
    hz.stall_if_id = rst_n & (memwait | loaduse_v);
    hz.stall_id_ex = rst_n & memwait;
    hz.stall_ex_mem = rst_n & memwait;
    hz.flush_if_id = rst_n & (redirect | (redir_like & ~memwait));
    hz.flush_id_ex = rst_n & (redirect | loaduse_v);
    hz.state_o = state_q;
    hz.mem_timeout = mem_timeout_q;
    state_d = RUN;
    rcnt_d = rcnt_q;
    wcnt_d = memwait ? ((state_q != MEM_WAIT) ? 8'd0 : (wcnt_q == 8'hff) ? wcnt_q : wcnt_q + 8'd1) : wcnt_q;
    mem_timeout_d = mem_timeout_q | (memwait && state_q == MEM_WAIT && wcnt_d == 8'(MEM_TIMEOUT));
    if (memwait) begin
      state_d = MEM_WAIT;
    end else if (redirect) begin
      state_d = (REDIRECT_BUBBLES > 0) ? REDIRECT : RUN;
      rcnt_d = 2'(REDIRECT_BUBBLES);
    end else if (state_q == REDIRECT) begin
      state_d = (rcnt_q == 2'd1) ? RUN : REDIRECT;
      rcnt_d = rcnt_q - 2'd1;
    end else if (redir_like) begin
      state_d = REDIRECT;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      rcnt_q <= 2'd0;
      wcnt_q <= 8'd0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rcnt_q <= rcnt_d;
      wcnt_q <= wcnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed vectors plus a cycle model checked on every falling edge
module tb_pipe_hazard_ctrl;
  localparam int RB = 1;
  localparam int TMO = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  pipe_hazard_ctrl_if #(.RD_WIDTH(5)) hz ();
  pipe_hazard_ctrl #(.RD_WIDTH(5), .REDIRECT_BUBBLES(RB), .MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .hz(hz)
  );
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: remaining redirect bubbles, whether a data access is outstanding, cycles waited
  int bub = 0;
  int wc = 0;
  bit inw = 0;
  bit tmo = 0;
  always @(negedge clk) begin
    logic e_spc, e_fif, e_sfz, e_fid;
    logic [1:0] e_st;
    bit busy, lu;
    e_spc = 0; e_fif = 0; e_sfz = 0; e_fid = 0; e_st = 0;
    if (!rst_n) begin
      bub = 0; inw = 0; wc = 0; tmo = 0;
      chk("m_tmo", hz.mem_timeout, 0);
    end else begin
      busy = inw ? !hz.mem_ack : (hz.mem_req_mem && !hz.mem_ack);
      lu = hz.mem_read_ex && hz.rd_ex != 0 &&
           ((hz.rs1_used_id && hz.rs1_id == hz.rd_ex) || (hz.rs2_used_id && hz.rs2_id == hz.rd_ex));
      e_st = inw ? 2'd1 : (bub > 0) ? 2'd2 : 2'd0;
      chk("m_tmo", hz.mem_timeout, tmo);
      if (busy) begin
        e_sfz = 1; e_spc = 1;
        wc = inw ? ((wc < 255) ? wc + 1 : wc) : 0;
        if (inw && wc == TMO) tmo = 1;
        inw = 1;
      end else if (bub > 0) begin
        e_fif = 1;
        if (!inw) bub--;
        inw = 0;
      end else begin
        inw = 0;
        if (hz.branch_taken_ex) begin
          e_fif = 1; e_fid = 1; bub = RB;
        end else if (lu) begin
          e_spc = 1; e_fid = 1;
        end
      end
    end
    chk("m_stall_pc", hz.stall_pc, e_spc);
    chk("m_stall_if_id", hz.stall_if_id, e_spc);
    chk("m_stall_id_ex", hz.stall_id_ex, e_sfz);
    chk("m_stall_ex_mem", hz.stall_ex_mem, e_sfz);
    chk("m_flush_if_id", hz.flush_if_id, e_fif);
    chk("m_flush_id_ex", hz.flush_id_ex, e_fid);
    chk("m_state", hz.state_o, e_st);
  end

  task automatic clr();
    hz.rs1_id = 0; hz.rs2_id = 0; hz.rd_ex = 0; hz.rs1_used_id = 0; hz.rs2_used_id = 0;
    hz.mem_read_ex = 0; hz.branch_taken_ex = 0; hz.mem_req_mem = 0; hz.mem_ack = 0;
  endtask
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask
  task automatic lu_setup();
    hz.mem_read_ex = 1; hz.rd_ex = 5; hz.rs1_id = 5; hz.rs1_used_id = 1;
  endtask

  initial begin
    clr();
    @(negedge clk);
    chk("rst_state", hz.state_o, 0);
    chk("rst_stall_pc", hz.stall_pc, 0);
    chk("rst_tmo", hz.mem_timeout, 0);
    nxt(); rst_n = 1;
    // load-use and its non-hazard variants
    lu_setup();
    @(negedge clk);
    chk("lu_stall_pc", hz.stall_pc, 1);
    chk("lu_stall_if_id", hz.stall_if_id, 1);
    chk("lu_flush_id_ex", hz.flush_id_ex, 1);
    nxt(); clr();
    @(negedge clk); chk("lu_after", hz.stall_pc, 0);
    nxt(); lu_setup(); hz.rd_ex = 0; hz.rs1_id = 0;
    @(negedge clk); chk("lu_x0", hz.flush_id_ex, 0);
    nxt(); lu_setup(); hz.rs1_used_id = 0;
    @(negedge clk); chk("lu_unused", hz.stall_pc, 0);
    nxt(); lu_setup(); hz.rs1_used_id = 0; hz.rs2_used_id = 1; hz.rs2_id = 5;
    @(negedge clk); chk("lu_rs2", hz.flush_id_ex, 1);
    // three-cycle data wait
    nxt(); clr(); hz.mem_req_mem = 1;
    @(negedge clk); chk("mw_st0", hz.state_o, 0); chk("mw_stall0", hz.stall_ex_mem, 1);
    nxt(); @(negedge clk); chk("mw_st1", hz.state_o, 1);
    nxt(); @(negedge clk); chk("mw_st2", hz.state_o, 1);
    nxt(); hz.mem_ack = 1;
    @(negedge clk); chk("mw_ack_st", hz.state_o, 1); chk("mw_ack_stall", hz.stall_pc, 0);
    nxt(); clr();
    @(negedge clk); chk("mw_end_st", hz.state_o, 0); chk("mw_tmo", hz.mem_timeout, 0);
    // branch redirect
    nxt(); hz.branch_taken_ex = 1;
    @(negedge clk); chk("br0_fif", hz.flush_if_id, 1); chk("br0_fid", hz.flush_id_ex, 1); chk("br0_spc", hz.stall_pc, 0);
    nxt(); hz.branch_taken_ex = 0;
    @(negedge clk); chk("br1_st", hz.state_o, 2); chk("br1_fif", hz.flush_if_id, 1); chk("br1_fid", hz.flush_id_ex, 0);
    nxt(); @(negedge clk); chk("br2_st", hz.state_o, 0);
    // branch beats load-use
    nxt(); lu_setup(); hz.branch_taken_ex = 1;
    @(negedge clk); chk("brlu_spc", hz.stall_pc, 0); chk("brlu_fid", hz.flush_id_ex, 1);
    nxt(); clr(); nxt();
    // branch held through a two-cycle wait
    nxt(); hz.branch_taken_ex = 1; hz.mem_req_mem = 1;
    @(negedge clk); chk("brmw_spc", hz.stall_pc, 1); chk("brmw_fif", hz.flush_if_id, 0);
    nxt(); @(negedge clk); chk("brmw_st", hz.state_o, 1);
    nxt(); hz.mem_ack = 1;
    @(negedge clk); chk("brmw_ack_fif", hz.flush_if_id, 1); chk("brmw_ack_fid", hz.flush_id_ex, 1);
    nxt(); clr();
    // data wait starting inside REDIRECT
    hz.mem_req_mem = 1;
    @(negedge clk); chk("rdmw_st", hz.state_o, 2); chk("rdmw_fif", hz.flush_if_id, 0);
    nxt(); hz.mem_ack = 1;
    @(negedge clk); chk("rdmw_ack_fif", hz.flush_if_id, 1);
    nxt(); clr();
    @(negedge clk); chk("rdmw_back", hz.state_o, 2);
    nxt(); nxt();
    // timeout after four waiting MEM_WAIT cycles
    hz.mem_req_mem = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 4) chk("tmo_c4", hz.mem_timeout, 0);
      if (i == 5) chk("tmo_c5", hz.mem_timeout, 1);
      nxt();
    end
    hz.mem_ack = 1;
    nxt(); clr();
    @(negedge clk); chk("tmo_sticky", hz.mem_timeout, 1);
    // asynchronous reset in the middle of a wait
    nxt(); hz.mem_req_mem = 1; nxt(); #2;
    rst_n = 0; #1;
    chk("ar_state", hz.state_o, 0);
    chk("ar_stall", hz.stall_ex_mem, 0);
    chk("ar_tmo", hz.mem_timeout, 0);
    nxt(); nxt(); rst_n = 1; clr();
    lu_setup();
    @(negedge clk); chk("ar_resume_lu", hz.stall_pc, 1);
    // mixed traffic checked by the model only
    for (int i = 0; i < 200; i++) begin
      nxt();
      hz.rs1_id = 5'($urandom_range(0, 3)); hz.rs2_id = 5'($urandom_range(0, 3));
      hz.rd_ex = 5'($urandom_range(0, 3));
      hz.rs1_used_id = 1'($urandom_range(0, 1)); hz.rs2_used_id = 1'($urandom_range(0, 1));
      hz.mem_read_ex = 1'($urandom_range(0, 1));
      hz.branch_taken_ex = ($urandom_range(0, 5) == 0);
      hz.mem_req_mem = ($urandom_range(0, 2) == 0);
      hz.mem_ack = 1'($urandom_range(0, 1));
    end
    nxt(); clr(); nxt();
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
